mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the 5-stage blocking pipeline; sits between the execute stage and the write-back stage.
- Accepts one instruction per handshake from EX and issues loads/stores on an SRAM-like data port (addr_ok/data_ok).
- Holds each instruction until its memory transaction completes, aligns and extends load data, and delivers the 70-bit MS→WS bus to write-back.
- Exports a hazard bus so the decode-stage interlock can stall on its destination register.

Parameters:
- none. Bus widths are the shared `ES_TO_MS_BUS_WD (106), `MS_TO_WS_BUS_WD (70) and `HAZARD_BUS_WD (7) from mycpu.h.

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
ms_allowin  output  1  MEM can accept an instruction from EX this cycle
es_to_ms_valid  input  1  EX is presenting a valid instruction
es_to_ms_bus  input  106  {mem_op[105:102], gr_we[101], dest[100:96], rt_value[95:64], alu_result[63:32], pc[31:0]}
ws_allowin  input  1  WB can accept an instruction this cycle
ms_to_ws_valid  output  1  MEM is presenting a completed instruction to WB
ms_to_ws_bus  output  70  {gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}
data_req  output  1  data-port request valid
data_wr  output  1  1 = store, 0 = load
data_size  output  2  0 = byte, 1 = half, 2 = word
data_addr  output  32  byte address, equal to alu_result
data_wstrb  output  4  byte-lane write enables
data_wdata  output  32  store data, replicated across lanes
data_addr_ok  input  1  request accepted by the data port
data_data_ok  input  1  response present this cycle
data_rdata  input  32  load data, valid when data_data_ok=1
ms_hazard_bus  output  7  {ms_valid, ms_gr_we, ms_dest}

Behaviour:
- mem_op encoding (4 bits): 0000 none, 0001 LB, 0010 LBU, 0011 LH, 0100 LHU, 0101 LW, 1001 SB, 1010 SH, 1011 SW. Any other code behaves as none.
- Registers: ms_valid, es_to_ms_bus_r, state (IDLE/REQ/WAIT/DONE), rdata_buf[31:0].
- Reset: ms_valid=0 and state=IDLE. Consequently data_req=0, ms_to_ws_valid=0, hazard bus valid=0. The bus register is not reset.
- Handshake with EX:
  - ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
  - When ms_allowin: ms_valid <= es_to_ms_valid.
  - When es_to_ms_valid && ms_allowin: latch the bus, and set state <= REQ for a memory op, otherwise IDLE.
- Handshake with WB: ms_to_ws_valid = ms_valid && ms_ready_go.
- ms_ready_go is 1 when any of the following holds:
  - the op is not a memory op;
  - state==WAIT && data_data_ok;
  - state==DONE.
- State transitions:
  - REQ: data_req=1. On data_addr_ok, go to WAIT.
  - WAIT: data_req=0. On data_data_ok with ws_allowin=1, the instruction leaves and state follows the next latch (or IDLE if nothing new is accepted). On data_data_ok with ws_allowin=0, capture rdata_buf <= data_rdata and go to DONE.
  - DONE: hold until ws_allowin=1, then the instruction leaves.
- Only one transaction is outstanding at a time. data_req never asserts in WAIT or DONE.
- data_addr, data_wr, data_size, data_wstrb and data_wdata stay stable from REQ until addr_ok.
- Store lanes, with a = alu_result[1:0]:
  - SB: wstrb = 1<<a; wdata = {4{rt[7:0]}}.
  - SH: wstrb = a[1] ? 1100 : 0011; wdata = {2{rt[15:0]}}.
  - SW: wstrb = 1111; wdata = rt.
  - Loads: wstrb = 0000.
- Load result: raw = (state==DONE) ? rdata_buf : data_rdata.
  - LB/LBU: select byte a, then sign- or zero-extend.
  - LH/LHU: select half a[1], then sign- or zero-extend.
  - LW: raw.
  - Non-load ops: final_result = alu_result.
- Misaligned addresses are not checked; the low address bits select lanes as above. Software guarantees alignment.
- Stores and non-memory ops pass gr_we through from EX; the decoder sets gr_we=0 for stores.
- Hazard bus: ms_valid, gr_we and dest are driven regardless of ready_go, so decode stalls for the whole memory wait.
- Reset mid-transaction: state returns to IDLE. The data memory shares the same reset, so no stale data_ok can arrive afterwards.
- Simultaneous completion and new entry: when data_ok, ws_allowin and es_to_ms_valid are all 1 in the same cycle, the new instruction is latched with its new state, giving zero bubble.

Decomposition:
- mycpu.h holds the bus-width macros and MEM_OP_* localparam codes, shared with the execute stage.
- State encodings stay local to this module.
- One natural sub-module: mem_load_align (combinational; inputs raw, a, mem_op; output aligned/extended data). It is reused by any future cache path.

Test Plan:
1. LW at addr 0x1004: addr_ok on cycle 1, data_ok on cycle 3 with rdata 0xDEADBEEF, ws_allowin=1 → ms_to_ws_bus final_result 0xDEADBEEF, ms_to_ws_valid high for exactly 1 cycle, ms_allowin high in the same cycle.
2. LB at addr 0x1003 with rdata 0x80112233 → result 0xFFFFFF80. LBU at the same address → 0x00000080. LH at 0x1002 → 0xFFFF8011.
3. SB at addr 0x2001 with rt 0x000000AB → data_wr=1, size=0, wstrb=0010, wdata=0xABABABAB. SH at 0x2002 → wstrb=1100.
4. LW with data_ok while ws_allowin=0 for 3 cycles → state DONE, ms_allowin=0, output held at the captured rdata even though data_rdata changes afterwards. ws_allowin=1 → the instruction leaves.
5. ADDU (op none) back-to-back with es_to_ms_valid=1 and ws_allowin=1 → one instruction per cycle, data_req never asserted, final_result = alu_result.
6. Reset asserted in WAIT → next cycle ms_valid=0, data_req=0, hazard bus bit6=0. A following LW issues data_req normally.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: bus widths, mem_op codes
// and small decode helpers that the execute stage also relies on.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 106;
    localparam int MS_TO_WS_BUS_WD = 70;
    localparam int HAZARD_BUS_WD   = 7;

    localparam logic [3:0] MEM_OP_NONE = 4'b0000;
    localparam logic [3:0] MEM_OP_LB   = 4'b0001;
    localparam logic [3:0] MEM_OP_LBU  = 4'b0010;
    localparam logic [3:0] MEM_OP_LH   = 4'b0011;
    localparam logic [3:0] MEM_OP_LHU  = 4'b0100;
    localparam logic [3:0] MEM_OP_LW   = 4'b0101;
    localparam logic [3:0] MEM_OP_SB   = 4'b1001;
    localparam logic [3:0] MEM_OP_SH   = 4'b1010;
    localparam logic [3:0] MEM_OP_SW   = 4'b1011;

    // Unknown codes fall through to "not a load" so they behave as no-op.
    function automatic logic op_is_load(input logic [3:0] op);
        case (op)
            MEM_OP_LB, MEM_OP_LBU, MEM_OP_LH, MEM_OP_LHU, MEM_OP_LW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        case (op)
            MEM_OP_SB, MEM_OP_SH, MEM_OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic op_is_mem(input logic [3:0] op);
        return op_is_load(op) || op_is_store(op);
    endfunction

    // Access size on the data port: 0 byte, 1 half, 2 word.
    function automatic logic [1:0] op_size(input logic [3:0] op);
        case (op)
            MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: return 2'd0;
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: return 2'd1;
            default: return 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Picks the addressed byte/half out of a 32-bit load word and extends it.
// Non-load codes pass the raw word through unchanged.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  a,
    input  logic [3:0]  mem_op,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection from the low address bits.
    always_comb begin
        case (a)
            2'd0:    byte_sel = raw[7:0];
            2'd1:    byte_sel = raw[15:8];
            2'd2:    byte_sel = raw[23:16];
            default: byte_sel = raw[31:24];
        endcase
        half_sel = a[1] ? raw[31:16] : raw[15:0];
    end

    // Sign or zero extension depending on the load flavour.
    always_comb begin
        case (mem_op)
            MEM_OP_LB:  result = {{24{byte_sel[7]}}, byte_sel};
            MEM_OP_LBU: result = {24'h000000, byte_sel};
            MEM_OP_LH:  result = {{16{half_sel[15]}}, half_sel};
            MEM_OP_LHU: result = {16'h0000, half_sel};
            default:    result = raw;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds one instruction from EX, runs its
// load/store on the SRAM-like data port and hands the result to WB.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    output logic                        ms_allowin,
    input  logic                        es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0]  es_to_ms_bus,
    input  logic                        ws_allowin,
    output logic                        ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0]  ms_to_ws_bus,
    output logic                        data_req,
    output logic                        data_wr,
    output logic [1:0]                  data_size,
    output logic [31:0]                 data_addr,
    output logic [3:0]                  data_wstrb,
    output logic [31:0]                 data_wdata,
    input  logic                        data_addr_ok,
    input  logic                        data_data_ok,
    input  logic [31:0]                 data_rdata,
    output logic [HAZARD_BUS_WD-1:0]    ms_hazard_bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                       state;
    logic                         ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0]   es_to_ms_bus_r;
    logic [31:0]                  rdata_buf;

    logic [3:0]  mem_op;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] rt_value;
    logic [31:0] alu_result;
    logic [31:0] pc;
    logic [3:0]  in_mem_op;
    logic        ms_ready_go;
    logic [31:0] load_raw;
    logic [31:0] load_aligned;
    logic [31:0] final_result;

    assign {mem_op, gr_we, dest, rt_value, alu_result, pc} = es_to_ms_bus_r;
    assign in_mem_op = es_to_ms_bus[105:102];

    assign ms_ready_go = !op_is_mem(mem_op)
                      || (state == ST_WAIT && data_data_ok)
                      || (state == ST_DONE);
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go;

    // Valid bit and transaction state; a newly accepted instruction always
    // overrides the old state, which gives zero-bubble back-to-back issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid <= 1'b0;
            state    <= ST_IDLE;
        end else if (ms_allowin) begin
            ms_valid <= es_to_ms_valid;
            if (es_to_ms_valid && op_is_mem(in_mem_op)) begin
                state <= ST_REQ;
            end else begin
                state <= ST_IDLE;
            end
        end else begin
            case (state)
                ST_REQ:  if (data_addr_ok) state <= ST_WAIT;
                ST_WAIT: if (data_data_ok) state <= ST_DONE;
                default: state <= state;
            endcase
        end
    end

    // Instruction payload from EX; deliberately not reset, ms_valid guards it.
    always_ff @(posedge clk) begin
        if (es_to_ms_valid && ms_allowin) begin
            es_to_ms_bus_r <= es_to_ms_bus;
        end
    end

    // Keep the load word when WB stalls, since the port only shows it once.
    always_ff @(posedge clk) begin
        if (state == ST_WAIT && data_data_ok && !ws_allowin) begin
            rdata_buf <= data_rdata;
        end
    end

    assign data_req  = ms_valid && (state == ST_REQ);
    assign data_wr   = op_is_store(mem_op);
    assign data_size = op_size(mem_op);
    assign data_addr = alu_result;

    // Byte-lane enables and lane-replicated store data.
    always_comb begin
        data_wstrb = 4'b0000;
        data_wdata = rt_value;
        case (mem_op)
            MEM_OP_SB: begin
                data_wstrb = 4'b0001 << alu_result[1:0];
                data_wdata = {4{rt_value[7:0]}};
            end
            MEM_OP_SH: begin
                data_wstrb = alu_result[1] ? 4'b1100 : 4'b0011;
                data_wdata = {2{rt_value[15:0]}};
            end
            MEM_OP_SW: begin
                data_wstrb = 4'b1111;
                data_wdata = rt_value;
            end
            default: begin
                data_wstrb = 4'b0000;
                data_wdata = rt_value;
            end
        endcase
    end

    assign load_raw = (state == ST_DONE) ? rdata_buf : data_rdata;

    mem_load_align u_load_align (
        .raw    (load_raw),
        .a      (alu_result[1:0]),
        .mem_op (mem_op),
        .result (load_aligned)
    );

    assign final_result  = op_is_load(mem_op) ? load_aligned : alu_result;
    assign ms_to_ws_bus  = {gr_we, dest, final_result, pc};
    assign ms_hazard_bus = {ms_valid, gr_we, dest};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a retire scoreboard: each accepted
// instruction pushes its expected {pc, result}; each retirement pops one.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         ms_allowin;
    logic         es_to_ms_valid;
    logic [105:0] es_to_ms_bus;
    logic         ws_allowin;
    logic         ms_to_ws_valid;
    logic [69:0]  ms_to_ws_bus;
    logic         data_req;
    logic         data_wr;
    logic [1:0]   data_size;
    logic [31:0]  data_addr;
    logic [3:0]   data_wstrb;
    logic [31:0]  data_wdata;
    logic         data_addr_ok;
    logic         data_data_ok;
    logic [31:0]  data_rdata;
    logic [6:0]   ms_hazard_bus;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] result;
    } exp_t;

    exp_t sb_q[$];
    exp_t pending;
    int   errors = 0;
    int   checks = 0;

    mem_stage dut (
        .clk            (clk),
        .reset          (reset),
        .ms_allowin     (ms_allowin),
        .es_to_ms_valid (es_to_ms_valid),
        .es_to_ms_bus   (es_to_ms_bus),
        .ws_allowin     (ws_allowin),
        .ms_to_ws_valid (ms_to_ws_valid),
        .ms_to_ws_bus   (ms_to_ws_bus),
        .data_req       (data_req),
        .data_wr        (data_wr),
        .data_size      (data_size),
        .data_addr      (data_addr),
        .data_wstrb     (data_wstrb),
        .data_wdata     (data_wdata),
        .data_addr_ok   (data_addr_ok),
        .data_data_ok   (data_data_ok),
        .data_rdata     (data_rdata),
        .ms_hazard_bus  (ms_hazard_bus)
    );

    always #5 clk = ~clk;

    // Hard stop if the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [105:0] mk(input logic [3:0] op, input logic we,
                                        input logic [4:0] dst, input logic [31:0] rt,
                                        input logic [31:0] alu, input logic [31:0] pcv);
        return {op, we, dst, rt, alu, pcv};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Inputs change at the falling edge; outputs are read 1ns later.
    task automatic applyStimulus(input logic rst, input logic ev, input logic [105:0] bus,
                                 input logic wsa, input logic aok, input logic dok,
                                 input logic [31:0] rd);
        reset          = rst;
        es_to_ms_valid = ev;
        es_to_ms_bus   = bus;
        ws_allowin     = wsa;
        data_addr_ok   = aok;
        data_data_ok   = dok;
        data_rdata     = rd;
        #1;
    endtask

    // Scoreboard bookkeeping for this cycle, then move to the next falling edge.
    task automatic advance();
        exp_t e;
        if (!reset && es_to_ms_valid && ms_allowin) sb_q.push_back(pending);
        if (!reset && ms_to_ws_valid && ws_allowin) begin
            checks++;
            assert (sb_q.size() != 0) else begin
                errors++;
                $error("[TB] FAIL retire_unexpected observed=pc 0x%08h expected=no retire",
                       ms_to_ws_bus[31:0]);
            end
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                checkOutput("retire_pc", ms_to_ws_bus[31:0], e.pc);
                checkOutput("retire_result", ms_to_ws_bus[63:32], e.result);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic doLoad(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] pcv,
                          input logic [31:0] rdata, input logic [31:0] exp_res,
                          input int wait_cycles);
        pending.pc     = pcv;
        pending.result = exp_res;
        applyStimulus(0, 1, mk(op, 1'b1, 5'd8, 32'h0, addr, pcv), 1, 0, 0, 32'h0);
        advance();
        applyStimulus(0, 0, '0, 1, 1, 0, 32'h0);
        checkOutput("load_req", 32'(data_req), 32'd1);
        checkOutput("load_addr", data_addr, addr);
        checkOutput("load_wr", 32'(data_wr), 32'd0);
        checkOutput("load_wstrb", 32'(data_wstrb), 32'd0);
        checkOutput("load_hazard", 32'(ms_hazard_bus), 32'h68);
        advance();
        for (int i = 0; i < wait_cycles; i++) begin
            applyStimulus(0, 0, '0, 1, 0, 0, 32'h0);
            checkOutput("load_wait_req", 32'(data_req), 32'd0);
            checkOutput("load_wait_valid", 32'(ms_to_ws_valid), 32'd0);
            checkOutput("load_wait_allowin", 32'(ms_allowin), 32'd0);
            advance();
        end
        applyStimulus(0, 0, '0, 1, 0, 1, rdata);
        checkOutput("load_done_valid", 32'(ms_to_ws_valid), 32'd1);
        checkOutput("load_done_allowin", 32'(ms_allowin), 32'd1);
        advance();
    endtask

    task automatic doStore(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] pcv,
                           input logic [31:0] rt, input logic [1:0] exp_size,
                           input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata);
        pending.pc     = pcv;
        pending.result = addr;
        applyStimulus(0, 1, mk(op, 1'b0, 5'd0, rt, addr, pcv), 1, 0, 0, 32'h0);
        advance();
        applyStimulus(0, 0, '0, 1, 1, 0, 32'h0);
        checkOutput("store_req", 32'(data_req), 32'd1);
        checkOutput("store_wr", 32'(data_wr), 32'd1);
        checkOutput("store_size", 32'(data_size), 32'(exp_size));
        checkOutput("store_wstrb", 32'(data_wstrb), 32'(exp_wstrb));
        checkOutput("store_wdata", data_wdata, exp_wdata);
        advance();
        applyStimulus(0, 0, '0, 1, 0, 1, 32'h0);
        checkOutput("store_gr_we", 32'(ms_to_ws_bus[69]), 32'd0);
        advance();
    endtask

    initial begin
        applyStimulus(1, 0, '0, 1, 0, 0, 32'h0);
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);

        $display("[TB] reset state");
        applyStimulus(0, 0, '0, 1, 0, 0, 32'h0);
        checkOutput("rst_allowin", 32'(ms_allowin), 32'd1);
        checkOutput("rst_valid", 32'(ms_to_ws_valid), 32'd0);
        checkOutput("rst_req", 32'(data_req), 32'd0);
        checkOutput("rst_hazard_v", 32'(ms_hazard_bus[6]), 32'd0);
        advance();

        $display("[TB] word load with a two-cycle wait");
        doLoad(MEM_OP_LW, 32'h0000_1004, 32'h0000_0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1);
        applyStimulus(0, 0, '0, 1, 0, 0, 32'h0);
        checkOutput("lw_valid_one_cycle", 32'(ms_to_ws_valid), 32'd0);
        advance();

        $display("[TB] byte and half loads");
        doLoad(MEM_OP_LB,  32'h0000_1003, 32'h0000_0104, 32'h8011_2233, 32'hFFFF_FF80, 0);
        doLoad(MEM_OP_LBU, 32'h0000_1003, 32'h0000_0108, 32'h8011_2233, 32'h0000_0080, 0);
        doLoad(MEM_OP_LH,  32'h0000_1002, 32'h0000_010C, 32'h8011_2233, 32'hFFFF_8011, 0);
        doLoad(MEM_OP_LHU, 32'h0000_1000, 32'h0000_0110, 32'h8011_A233, 32'h0000_A233, 0);

        $display("[TB] stores");
        doStore(MEM_OP_SB, 32'h0000_2001, 32'h0000_0200, 32'h0000_00AB, 2'd0, 4'b0010, 32'hABAB_ABAB);
        doStore(MEM_OP_SH, 32'h0000_2002, 32'h0000_0204, 32'h0000_1234, 2'd1, 4'b1100, 32'h1234_1234);
        doStore(MEM_OP_SW, 32'h0000_2008, 32'h0000_0208, 32'h5566_7788, 2'd2, 4'b1111, 32'h5566_7788);

        $display("[TB] load completing while WB stalls");
        pending.pc     = 32'h0000_0300;
        pending.result = 32'h1234_5678;
        applyStimulus(0, 1, mk(MEM_OP_LW, 1'b1, 5'd8, 32'h0, 32'h0000_3000, 32'h0000_0300),
                      1, 0, 0, 32'h0);
        advance();
        applyStimulus(0, 0, '0, 0, 1, 0, 32'h0);
        advance();
        applyStimulus(0, 0, '0, 0, 0, 1, 32'h1234_5678);
        checkOutput("stall_ok_allowin", 32'(ms_allowin), 32'd0);
        advance();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, '0, 0, 0, 0, 32'hFFFF_0000 + 32'(i));
            checkOutput("stall_allowin", 32'(ms_allowin), 32'd0);
            checkOutput("stall_valid", 32'(ms_to_ws_valid), 32'd1);
            checkOutput("stall_held_data", ms_to_ws_bus[63:32], 32'h1234_5678);
            checkOutput("stall_req", 32'(data_req), 32'd0);
            advance();
        end
        applyStimulus(0, 0, '0, 1, 0, 0, 32'hFFFF_FFFF);
        checkOutput("stall_release_allowin", 32'(ms_allowin), 32'd1);
        advance();

        $display("[TB] back-to-back ALU ops");
        for (int i = 0; i < 4; i++) begin
            pending.pc     = 32'h0000_0600 + 32'(4 * i);
            pending.result = 32'h0000_0100 + 32'(i);
            applyStimulus(0, 1, mk(MEM_OP_NONE, 1'b1, 5'd9, 32'h0, pending.result, pending.pc),
                          1, 0, 0, 32'h0);
            checkOutput("addu_req", 32'(data_req), 32'd0);
            checkOutput("addu_allowin", 32'(ms_allowin), 32'd1);
            if (i > 0) checkOutput("addu_valid", 32'(ms_to_ws_valid), 32'd1);
            advance();
        end
        applyStimulus(0, 0, '0, 1, 0, 0, 32'h0);
        checkOutput("addu_last_valid", 32'(ms_to_ws_valid), 32'd1);
        advance();

        $display("[TB] completion and new entry in the same cycle");
        pending.pc     = 32'h0000_0700;
        pending.result = 32'hCAFE_F00D;
        applyStimulus(0, 1, mk(MEM_OP_LW, 1'b1, 5'd8, 32'h0, 32'h0000_5000, 32'h0000_0700),
                      1, 0, 0, 32'h0);
        advance();
        applyStimulus(0, 0, '0, 1, 1, 0, 32'h0);
        advance();
        pending.pc     = 32'h0000_0704;
        pending.result = 32'h0102_0304;
        applyStimulus(0, 1, mk(MEM_OP_LW, 1'b1, 5'd8, 32'h0, 32'h0000_5004, 32'h0000_0704),
                      1, 0, 1, 32'hCAFE_F00D);
        checkOutput("overlap_allowin", 32'(ms_allowin), 32'd1);
        advance();
        applyStimulus(0, 0, '0, 1, 1, 0, 32'h0);
        checkOutput("overlap_next_req", 32'(data_req), 32'd1);
        checkOutput("overlap_next_addr", data_addr, 32'h0000_5004);
        advance();
        applyStimulus(0, 0, '0, 1, 0, 1, 32'h0102_0304);
        advance();

        $display("[TB] reset during a wait");
        pending.pc     = 32'h0000_0800;
        pending.result = 32'h0;
        applyStimulus(0, 1, mk(MEM_OP_LW, 1'b1, 5'd8, 32'h0, 32'h0000_6000, 32'h0000_0800),
                      1, 0, 0, 32'h0);
        advance();
        applyStimulus(0, 0, '0, 1, 1, 0, 32'h0);
        advance();
        applyStimulus(1, 0, '0, 1, 0, 0, 32'h0);
        advance();
        sb_q.delete();
        applyStimulus(0, 0, '0, 1, 0, 0, 32'h0);
        checkOutput("midrst_valid", 32'(ms_to_ws_valid), 32'd0);
        checkOutput("midrst_req", 32'(data_req), 32'd0);
        checkOutput("midrst_hazard_v", 32'(ms_hazard_bus[6]), 32'd0);
        advance();
        doLoad(MEM_OP_LW, 32'h0000_6004, 32'h0000_0804, 32'h0BAD_F00D, 32'h0BAD_F00D, 0);

        checkOutput("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
